pixel_window_loader: RTL and testbench
======================================

# pixel_window_loader

Front-end stage of the edge-detection datapath. Captures a 20×20 image of 5-bit pixels arriving five per cycle on `pixel_in0..4`, stores it in an internal frame buffer, then streams one zero-padded 3×3 neighbourhood per pixel, in raster order, to the downstream filter/edge core over a valid/ready handshake. It decouples the fixed-rate pixel loading interface from the variable-rate filtering pipeline.

## Interface
- `IMG_W`, 20, image width in pixels; must be a multiple of `LANES`
- `IMG_H`, 20, image height in pixels
- `PIX_W`, 5, bits per pixel
- `LANES`, 5, pixels accepted per load cycle
---
- `clk`  in  1  single clock; all logic is rising-edge
- `reset`  in  1  synchronous, active-high; one clock; the polarity and synchronicity are fixed
- `pixel_in0`..`pixel_in4`  in  PIX_W each  pixel group; `pixel_in0` is the lowest raster index
- `load_valid`  in  1  group on `pixel_in*` is valid this cycle
- `load_end`  in  1  qualified by `load_valid`; marks the last group of the frame
- `win_data`  out  9*PIX_W  window taps w0..w8, w0 at LSBs; row-major, w4 = centre
- `win_valid`  out  1  `win_data` is valid
- `win_ready`  in  1  downstream accepts the window
- `win_last`  out  1  window is the frame's last (centre index IMG_W*IMG_H-1)
- `frame_done`  out  1  all windows delivered; sticky until reset

## Operation
- States: LOAD → STREAM → DONE. Reset → LOAD.
- LOAD: each cycle with `load_valid`=1 writes the group to raster indices `wptr..wptr+4`; `wptr` advances by `LANES`.
- LOAD exits to STREAM after a group with `load_end`=1, or after the group filling index IMG_W*IMG_H-1, whichever comes first. Groups arriving in STREAM/DONE are ignored.
- Early `load_end`: unwritten pixels read as 0 (buffer is cleared by reset).
- STREAM: centre counter (r,c) starts at (0,0). Tap (dr,dc), dr,dc∈{-1,0,1}, maps to w[(dr+1)*3+(dc+1)] = pixel(r+dr, c+dc), or 0 when outside the image (zero padding).
- Window advances on `win_valid && win_ready`: c increments; c wraps to 0 at IMG_W with r+1.
- Handshake on the window with `win_last`=1 → DONE; `win_valid` drops, `frame_done`=1.
- DONE holds until `reset`; a new frame requires `reset`.
- `reset` at any time: state LOAD, `wptr`=0, (r,c)=(0,0), buffer cleared, outputs at reset values.

## Timing
- Reset values: `win_valid`=0, `win_last`=0, `frame_done`=0, `win_data`=0.
- `win_data`, `win_valid`, `win_last` are registered. First `win_valid` rises 2 cycles after the terminating load group is sampled (1 cycle state change, 1 cycle window register).
- With `win_ready` held high: one window per cycle, IMG_W*IMG_H windows back-to-back.
- `win_ready`=0: `win_data`/`win_last` held stable, `win_valid` stays 1; no window is dropped or repeated.
- `frame_done` rises the cycle after the last handshake; `win_valid` is 0 in that same cycle.

## Structure
- Shared package `edge_pkg`: IMG_W, IMG_H, PIX_W, LANES defaults, state enum {LOAD, STREAM, DONE}, window tap index constants.
- Sub-module `frame_buf`: IMG_W*IMG_H×PIX_W register array, one LANES-wide write port, nine read taps with out-of-range → 0; the top holds the FSM, counters and output register.

## Test plan
- Full frame, pixel k = k mod 32, `load_valid`=1 for 80 cycles, `load_end` on group 79, `win_ready`=1 → 400 windows; centre (0,0) = {0,0,0, 0,0,1, 0,20,21}; (1,1) = {0,1,2, 20,21,22, 8,9,10}; (19,19) w0=26, w4=15, w5..w8=0, `win_last`=1.
- Random `win_ready` backpressure on the same frame → identical window sequence, `win_data` stable whenever `win_valid`=1 and `win_ready`=0.
- `load_end` on group 3 (pixels 0..19) → row 0 loaded; centre (1,0) w7=w8=0; 400 windows still delivered.
- 85 groups without `load_end` → STREAM entered after group 79; groups 80..84 ignored; windows match the 400-pixel frame.
- `reset` asserted mid-STREAM at window 150 → next cycle `win_valid`=0, `frame_done`=0; reloading a frame restarts at centre (0,0) with cleared prior data.
- After last handshake → `frame_done`=1, `win_valid`=0, held for 100 cycles regardless of `load_valid`/`win_ready`.

Source files
------------

// File: rtl/edge_pkg.sv
// Shared constants and types for the edge-detection datapath.
// Image geometry defaults, FSM states and 3x3 window tap indices.
package edge_pkg;

    localparam int DEF_IMG_W = 20;
    localparam int DEF_IMG_H = 20;
    localparam int DEF_PIX_W = 5;
    localparam int DEF_LANES = 5;

    localparam int NTAPS  = 9;
    localparam int TAP_NW = 0;
    localparam int TAP_N  = 1;
    localparam int TAP_NE = 2;
    localparam int TAP_W  = 3;
    localparam int TAP_C  = 4;
    localparam int TAP_E  = 5;
    localparam int TAP_SW = 6;
    localparam int TAP_S  = 7;
    localparam int TAP_SE = 8;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/frame_buf.sv
// Frame buffer: one LANES-wide write port, nine zero-padded read taps
// around the centre pixel (row_i, col_i).
module frame_buf
    import edge_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int PIX_W = DEF_PIX_W,
    parameter int LANES = DEF_LANES,
    localparam int NPIX = IMG_W * IMG_H,
    localparam int AW   = $clog2(NPIX),
    localparam int RW   = $clog2(IMG_H + 1),
    localparam int CW   = $clog2(IMG_W)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we_i,
    input  logic [AW-1:0]          waddr_i,
    input  logic [LANES*PIX_W-1:0] wdata_i,
    input  logic [RW-1:0]          row_i,
    input  logic [CW-1:0]          col_i,
    output logic [NTAPS*PIX_W-1:0] taps_o
);

    logic [PIX_W-1:0] mem_q [NPIX];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NPIX; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            for (int l = 0; l < LANES; l++) begin
                mem_q[waddr_i + AW'(l)] <= wdata_i[l*PIX_W +: PIX_W];
            end
        end
    end

    int          rr;
    int          cc;
    logic [AW-1:0] idx;

    // Taps outside the image read as zero (padding).
    always_comb begin
        taps_o = '0;
        rr     = 0;
        cc     = 0;
        idx    = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                rr = int'(row_i) + dr;
                cc = int'(col_i) + dc;
                if (rr >= 0 && rr < IMG_H && cc >= 0 && cc < IMG_W) begin
                    idx = AW'(rr * IMG_W + cc);
                    taps_o[(TAP_C + dr*3 + dc)*PIX_W +: PIX_W] = mem_q[idx];
                end
            end
        end
    end

endmodule

// File: rtl/pixel_window_loader.sv
// Loads a frame into frame_buf, then streams one padded 3x3 window per
// pixel in raster order over a valid/ready handshake.
module pixel_window_loader
    import edge_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int PIX_W = DEF_PIX_W,
    parameter int LANES = DEF_LANES
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PIX_W-1:0]       pixel_in0,
    input  logic [PIX_W-1:0]       pixel_in1,
    input  logic [PIX_W-1:0]       pixel_in2,
    input  logic [PIX_W-1:0]       pixel_in3,
    input  logic [PIX_W-1:0]       pixel_in4,
    input  logic                   load_valid,
    input  logic                   load_end,
    output logic [NTAPS*PIX_W-1:0] win_data,
    output logic                   win_valid,
    input  logic                   win_ready,
    output logic                   win_last,
    output logic                   frame_done
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int AW   = $clog2(NPIX);
    localparam int RW   = $clog2(IMG_H + 1);
    localparam int CW   = $clog2(IMG_W);

    state_e state_q, state_d;

    logic [AW-1:0]          wptr_q, wptr_d;
    logic [RW-1:0]          row_q, row_d;
    logic [CW-1:0]          col_q, col_d;
    logic                   issued_q, issued_d;
    logic [NTAPS*PIX_W-1:0] data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   last_q, last_d;
    logic                   done_q, done_d;

    logic                   wr_en;
    logic                   issue;
    logic                   hs;
    logic                   at_end;
    logic [LANES*PIX_W-1:0] grp;
    logic [NTAPS*PIX_W-1:0] taps;

    assign grp    = {pixel_in4, pixel_in3, pixel_in2, pixel_in1, pixel_in0};
    assign hs     = valid_q && win_ready;
    assign at_end = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));

    frame_buf #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .PIX_W (PIX_W),
        .LANES (LANES)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .we_i    (wr_en),
        .waddr_i (wptr_q),
        .wdata_i (grp),
        .row_i   (row_q),
        .col_i   (col_q),
        .taps_o  (taps)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD: begin
                if (load_valid &&
                    (load_end || wptr_q == AW'(NPIX - LANES))) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (hs && last_q) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = LOAD;
        endcase
    end

    // A new window is fetched whenever the output register is free.
    always_comb begin
        wr_en = 1'b0;
        issue = 1'b0;
        unique case (state_q)
            LOAD:    wr_en = load_valid;
            STREAM:  issue = !issued_q && (!valid_q || win_ready);
            default: ;
        endcase
    end

    always_comb begin
        wptr_d   = wptr_q;
        row_d    = row_q;
        col_d    = col_q;
        issued_d = issued_q;
        data_d   = data_q;
        valid_d  = valid_q;
        last_d   = last_q;
        done_d   = done_q;
        if (wr_en) begin
            wptr_d = wptr_q + AW'(LANES);
        end
        if (issue) begin
            data_d   = taps;
            valid_d  = 1'b1;
            last_d   = at_end;
            issued_d = at_end;
            if (col_q == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end else if (hs) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
        if (state_q == STREAM && hs && last_q) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q   <= '0;
            row_q    <= '0;
            col_q    <= '0;
            issued_q <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            row_q    <= row_d;
            col_q    <= col_d;
            issued_q <= issued_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            done_q   <= done_d;
        end
    end

    assign win_data   = data_q;
    assign win_valid  = valid_q;
    assign win_last   = last_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_pixel_window_loader.sv
// Bench for pixel_window_loader: image model, padded-window reference,
// per-cycle output checker and randomized backpressure.
module tb_pixel_window_loader;

    localparam int W = 20;
    localparam int H = 20;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  pin [5];
    logic        load_valid = 1'b0;
    logic        load_end = 1'b0;
    logic        win_ready = 1'b1;
    logic [44:0] win_data;
    logic        win_valid;
    logic        win_last;
    logic        frame_done;

    int img [N];
    int exp_idx = 0;
    bit ready_rand = 1'b0;
    int n_c = 0, bad_c = 0;
    int n_i = 0, bad_i = 0;

    logic        prev_v = 1'b0;
    logic        prev_r = 1'b0;
    logic [44:0] prev_d = '0;
    logic        prev_l = 1'b0;

    always #5 clk = ~clk;

    pixel_window_loader dut (
        .clk        (clk),
        .reset      (reset),
        .pixel_in0  (pin[0]),
        .pixel_in1  (pin[1]),
        .pixel_in2  (pin[2]),
        .pixel_in3  (pin[3]),
        .pixel_in4  (pin[4]),
        .load_valid (load_valid),
        .load_end   (load_end),
        .win_data   (win_data),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_last   (win_last),
        .frame_done (frame_done)
    );

    function automatic logic [44:0] model_win(input int idx);
        logic [44:0] w;
        int r, c, rr, cc;
        w = '0;
        r = idx / W;
        c = idx % W;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                rr = r + dr - 1;
                cc = c + dc - 1;
                if (rr >= 0 && rr < H && cc >= 0 && cc < W)
                    w[(dr*3+dc)*5 +: 5] = 5'(img[rr*W+cc]);
            end
        end
        return w;
    endfunction

    function automatic logic [44:0] pack9(input int v[9]);
        logic [44:0] w;
        w = '0;
        for (int i = 0; i < 9; i++) w[i*5 +: 5] = 5'(v[i]);
        return w;
    endfunction

    task automatic ck_c(input bit ok, input string nm,
                        input logic [63:0] act, input logic [63:0] req);
        n_c++;
        if (!ok) begin
            bad_c++;
            if (bad_c < 30)
                $display("FAIL %s at idx %0d: got %0h want %0h",
                         nm, exp_idx, act, req);
        end
    endtask

    task automatic ck_i(input bit ok, input string nm,
                        input logic [63:0] act, input logic [63:0] req);
        n_i++;
        if (!ok) begin
            bad_i++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    // Per-cycle checker; also drives win_ready.
    always @(posedge clk) begin
        logic [44:0] m;
        #1;
        if (reset) begin
            ck_c(win_valid == 1'b0, "rst_valid", 64'(win_valid), 0);
            ck_c(win_last == 1'b0, "rst_last", 64'(win_last), 0);
            ck_c(frame_done == 1'b0, "rst_done", 64'(frame_done), 0);
            ck_c(win_data == '0, "rst_data", 64'(win_data), 0);
            exp_idx = 0;
            prev_v  = 1'b0;
            prev_r  = 1'b0;
        end else begin
            if (prev_v && prev_r) exp_idx++;
            ck_c(frame_done == (exp_idx == N), "frame_done",
                 64'(frame_done), 64'(exp_idx == N));
            if (win_valid) begin
                if (exp_idx >= N) begin
                    ck_c(1'b0, "extra_window", 64'(win_valid), 0);
                end else begin
                    m = model_win(exp_idx);
                    ck_c(win_data == m, "win_data", 64'(win_data), 64'(m));
                    ck_c(win_last == (exp_idx == N - 1), "win_last",
                         64'(win_last), 64'(exp_idx == N - 1));
                end
                if (prev_v && !prev_r) begin
                    ck_c(win_data == prev_d && win_last == prev_l,
                         "stall_stable", 64'(win_data), 64'(prev_d));
                end
            end else if (prev_v && !prev_r) begin
                ck_c(1'b0, "valid_dropped", 0, 1);
            end
            if (!ready_rand && prev_v && prev_r && exp_idx < N) begin
                ck_c(win_valid == 1'b1, "back_to_back", 64'(win_valid), 1);
            end
        end
        prev_v = win_valid;
        prev_d = win_data;
        prev_l = win_last;
        win_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        prev_r = win_ready;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        load_valid = 1'b0;
        load_end = 1'b0;
        for (int i = 0; i < N; i++) img[i] = 0;
        step();
        reset = 1'b0;
    endtask

    task automatic load(input int ng, input int endg,
                        input bit rnd, input bit lat);
        bit term;
        int v;
        term = 1'b0;
        for (int g = 0; g < ng; g++) begin
            for (int l = 0; l < 5; l++) begin
                v = rnd ? int'($urandom_range(0, 31)) : (g*5 + l) % 32;
                pin[l] = 5'(v);
                if (!term && g*5 + l < N) img[g*5+l] = v;
            end
            load_valid = 1'b1;
            load_end = (g == endg);
            if (g == endg || g*5 + 5 >= N) term = 1'b1;
            step();
        end
        load_valid = 1'b0;
        load_end = 1'b0;
        if (lat) begin
            ck_i(win_valid == 1'b0, "latency_early", 64'(win_valid), 0);
            step();
            ck_i(win_valid == 1'b1, "latency_2cyc", 64'(win_valid), 1);
        end
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (!frame_done && k < budget) begin
            step();
            k++;
        end
        ck_i(frame_done == 1'b1, "done_timeout", 64'(frame_done), 1);
    endtask

    initial begin
        int v9[9];
        logic [44:0] w;
        for (int l = 0; l < 5; l++) pin[l] = '0;
        for (int i = 0; i < N; i++) img[i] = 0;
        step();
        step();
        reset = 1'b0;
        step();

        // Full frame, k mod 32, ready held high
        ready_rand = 1'b0;
        load(80, 79, 1'b0, 1'b1);
        v9 = '{0, 0, 0, 0, 0, 1, 0, 20, 21};
        ck_i(model_win(0) == pack9(v9), "pin_00", 64'(model_win(0)), 64'(pack9(v9)));
        v9 = '{0, 1, 2, 20, 21, 22, 8, 9, 10};
        ck_i(model_win(21) == pack9(v9), "pin_11", 64'(model_win(21)), 64'(pack9(v9)));
        v9 = '{26, 27, 0, 14, 15, 0, 0, 0, 0};
        ck_i(model_win(399) == pack9(v9), "pin_1919", 64'(model_win(399)), 64'(pack9(v9)));
        wait_done(3000);
        ck_i(exp_idx == N, "win_count", 64'(exp_idx), 64'(N));

        // DONE holds regardless of inputs
        ready_rand = 1'b1;
        repeat (100) begin
            load_valid = 1'($urandom_range(0, 1));
            load_end = 1'($urandom_range(0, 1));
            for (int l = 0; l < 5; l++) pin[l] = 5'($urandom_range(0, 31));
            step();
        end
        load_valid = 1'b0;
        load_end = 1'b0;
        ck_i(frame_done == 1'b1 && win_valid == 1'b0, "done_hold",
             64'({frame_done, win_valid}), 64'(2'b10));

        // Same frame with random backpressure
        do_reset();
        load(80, 79, 1'b0, 1'b1);
        wait_done(4000);

        // 85 groups, no load_end: auto-exit after group 79
        do_reset();
        load(85, -1, 1'b1, 1'b0);
        wait_done(4000);

        // Reset mid-stream, then short reload
        do_reset();
        ready_rand = 1'b0;
        load(80, 79, 1'b1, 1'b1);
        begin
            int k;
            k = 0;
            while (exp_idx < 150 && k < 1000) begin
                step();
                k++;
            end
            ck_i(exp_idx >= 150, "reach_150", 64'(exp_idx), 150);
        end
        do_reset();
        step();
        ck_i(win_valid == 1'b0 && frame_done == 1'b0, "post_rst",
             64'({win_valid, frame_done}), 0);
        ready_rand = 1'b1;
        load(4, 3, 1'b1, 1'b1);
        w = model_win(20);
        ck_i(w[7*5 +: 10] == '0, "pin_10_w78", 64'(w[7*5 +: 10]), 0);
        wait_done(4000);
        ck_i(exp_idx == N, "short_count", 64'(exp_idx), 64'(N));

        step();
        $display("test done: total=%0d bad=%0d", n_c + n_i, bad_c + bad_i);
        $finish;
    end

endmodule
